// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, ALU opcodes,
// instruction field layout and the single-bit mask helper.
package alu_seq_pkg;

  localparam int OP_W   = 4;
  localparam int IMM_W  = 8;
  localparam int INST_W = OP_W + IMM_W;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_PASSB = 4'd0;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_INC   = 4'd5;
  localparam logic [OP_W-1:0] OP_DEC   = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_NOP   = 4'd8;
  localparam logic [OP_W-1:0] OP_CLR   = 4'd9;
  localparam logic [OP_W-1:0] OP_IOR   = 4'd10;
  localparam logic [OP_W-1:0] OP_SWAP  = 4'd11;
  localparam logic [OP_W-1:0] OP_COM   = 4'd12;
  localparam logic [OP_W-1:0] OP_BCF   = 4'd13;
  localparam logic [OP_W-1:0] OP_BSF   = 4'd14;
  localparam logic [OP_W-1:0] OP_CTL   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
  } inst_t;

  // One-hot mask selecting bit n of a data byte.
  function automatic logic [DATA_W-1:0] bit_mask(input logic [2:0] n);
    return 8'h01 << n;
  endfunction

endpackage

// File: rtl/alu_seq_opmap.sv
// Combinational translation of an instruction into the ALU opcode/operand
// actually driven, plus whether the result may update the carry flag.
module alu_seq_opmap
  import alu_seq_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [IMM_W-1:0]  imm,
  output logic [OP_W-1:0]   alu_inst,
  output logic [DATA_W-1:0] alu_a,
  output logic              carry_en
);

  // Bit clear/set are not native ALU ops: rewrite them as AND/IOR with a mask.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    alu_inst = op;
    alu_a    = imm;
    carry_en = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    case (op)
      OP_BCF: begin
        alu_inst = OP_AND;
        alu_a    = ~bit_mask(imm[2:0]);
      end
      OP_BSF: begin
        alu_inst = OP_IOR;
        alu_a    = bit_mask(imm[2:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer running a program from a synchronous ROM on an external 8-bit ALU.
// Owns pc, accumulator, C/Z flags and a watchdog counting written-back results.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int PC_W     = 7,
  parameter int WDOG_MAX = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rom_en,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [OP_W-1:0]   alu_inst,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W:0]   alu_ans,
  output logic [DATA_W-1:0] acc_out,
  output logic              flag_c,
  output logic              flag_z,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int STEP_W = $clog2(WDOG_MAX + 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                c_q, c_d, z_q, z_d;
  logic [STEP_W-1:0]   step_q, step_d;
  inst_t               ir_q, ir_d;
  logic                rom_en_q, rom_en_d, busy_q, busy_d;
  logic                done_q, done_d, err_q, err_d;
  logic [OP_W-1:0]     alu_inst_q, alu_inst_d, map_inst;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, map_a;
  logic                map_carry_en;

  // Instruction register captures the ROM word in DECODE and holds it after.
  always_comb begin
    ir_d = (state_q == ST_DECODE) ? inst_t'(rom_data) : ir_q;
  end

  alu_seq_opmap u_opmap (
    .op       (ir_d.op),
    .imm      (ir_d.imm),
    .alu_inst (map_inst),
    .alu_a    (map_a),
    .carry_en (map_carry_en)
  );

  // Next-state and architectural-state update for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    step_d  = step_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          c_d     = 1'b0;
          z_d     = 1'b0;
          step_d  = '0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (ir_d.op == OP_CTL) begin
          if (ir_d.imm[7]) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            pc_d    = z_q ? pc_q + PC_W'(1) : ir_d.imm[PC_W-1:0];
          end
        end else if (ir_d.op == OP_NOP) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + PC_W'(1);
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        acc_d  = alu_ans[DATA_W-1:0];
        z_d    = (alu_ans[DATA_W-1:0] == '0);
        if (map_carry_en) c_d = alu_ans[DATA_W];
        pc_d   = pc_q + PC_W'(1);
        step_d = step_q + STEP_W'(1);
        if (step_d == STEP_W'(WDOG_MAX)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    rom_en_d   = (state_d == ST_FETCH);
    busy_d     = (state_d != ST_IDLE);
    alu_inst_d = OP_NOP;
    alu_a_d    = '0;
    if ((state_d == ST_EXEC) || (state_d == ST_WB)) begin
      alu_inst_d = map_inst;
      alu_a_d    = map_a;
    end
  end

  // Single state register for the FSM, its datapath and its outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      step_q     <= '0;
      ir_q       <= '0;
      rom_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      alu_inst_q <= OP_NOP;
      alu_a_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      c_q        <= c_d;
      z_q        <= z_d;
      step_q     <= step_d;
      ir_q       <= ir_d;
      rom_en_q   <= rom_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      alu_inst_q <= alu_inst_d;
      alu_a_q    <= alu_a_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = pc_q;
  assign alu_inst = alu_inst_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = acc_q;
  assign acc_out  = acc_q;
  assign flag_c   = c_q;
  assign flag_z   = z_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: bench-side ROM and ALU models, a scoreboard of
// expected end-of-program results, and a second instance with a tiny watchdog.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_m = 1'b0, start_w = 1'b0;

  logic [11:0] rom [0:127];

  logic        m_rom_en, w_rom_en;
  logic [6:0]  m_rom_addr, w_rom_addr;
  logic [11:0] m_rom_data = '0, w_rom_data = '0;
  logic [3:0]  m_alu_inst, w_alu_inst;
  logic [7:0]  m_alu_a, w_alu_a, m_alu_b, w_alu_b;
  logic [8:0]  m_alu_ans, w_alu_ans;
  logic [7:0]  m_acc, w_acc;
  logic        m_c, w_c, m_z, w_z, m_busy, w_busy, m_done, w_done, m_err, w_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference ALU: sub/dec compute b - a / b - 1 with borrow in bit 8.
  function automatic logic [8:0] alu_model(input logic [3:0] inst, input logic [7:0] a,
                                           input logic [7:0] b);
    case (inst)
      4'd0:    return {1'b0, b};
      4'd1:    return {1'b0, a};
      4'd2:    return {1'b0, a} + {1'b0, b};
      4'd3:    return {1'b0, b} - {1'b0, a};
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, b} + 9'd1;
      4'd6:    return {1'b0, b} - 9'd1;
      4'd7:    return {1'b0, a ^ b};
      4'd9:    return 9'd0;
      4'd10:   return {1'b0, a | b};
      4'd11:   return {1'b0, b[3:0], b[7:4]};
      4'd12:   return {1'b0, ~b};
      default: return {1'b0, b};
    endcase
  endfunction

  assign m_alu_ans = alu_model(m_alu_inst, m_alu_a, m_alu_b);
  assign w_alu_ans = alu_model(w_alu_inst, w_alu_a, w_alu_b);

  // Synchronous ROMs: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (m_rom_en) m_rom_data <= rom[m_rom_addr];
    if (w_rom_en) w_rom_data <= rom[w_rom_addr];
  end

  alu_seq_ctrl #(.PC_W(7), .WDOG_MAX(1000)) u_main (
    .clk(clk), .reset(reset), .start(start_m), .rom_en(m_rom_en), .rom_addr(m_rom_addr),
    .rom_data(m_rom_data), .alu_inst(m_alu_inst), .alu_a(m_alu_a), .alu_b(m_alu_b),
    .alu_ans(m_alu_ans), .acc_out(m_acc), .flag_c(m_c), .flag_z(m_z), .busy(m_busy),
    .done(m_done), .err(m_err)
  );

  alu_seq_ctrl #(.PC_W(7), .WDOG_MAX(4)) u_wdog (
    .clk(clk), .reset(reset), .start(start_w), .rom_en(w_rom_en), .rom_addr(w_rom_addr),
    .rom_data(w_rom_data), .alu_inst(w_alu_inst), .alu_a(w_alu_a), .alu_b(w_alu_b),
    .alu_ans(w_alu_ans), .acc_out(w_acc), .flag_c(w_c), .flag_z(w_z), .busy(w_busy),
    .done(w_done), .err(w_err)
  );

  // Observation mux: sel=1 watches the watchdog instance.
  bit         sel = 1'b0;
  logic [7:0] o_acc;
  logic       o_c, o_z, o_busy, o_done, o_err, o_rom_en;
  always_comb begin
    o_acc    = sel ? w_acc    : m_acc;
    o_c      = sel ? w_c      : m_c;
    o_z      = sel ? w_z      : m_z;
    o_busy   = sel ? w_busy   : m_busy;
    o_done   = sel ? w_done   : m_done;
    o_err    = sel ? w_err    : m_err;
    o_rom_en = sel ? w_rom_en : m_rom_en;
  end

  typedef struct {
    string      tag;
    logic [7:0] acc;
    logic       c, z, done, err;
    int         cycles, fetches;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 12'hF80;
  endtask

  task automatic set_rom(input int addr, input logic [3:0] op, input logic [7:0] imm);
    rom[addr] = {op, imm};
  endtask

  task automatic push_exp(input string tag, input logic [7:0] acc, input logic c, input logic z,
                          input logic dn, input logic er, input int cyc, input int fet);
    exp_t e;
    e.tag = tag; e.acc = acc; e.c = c; e.z = z; e.done = dn; e.err = er;
    e.cycles = cyc; e.fetches = fet;
    sb.push_back(e);
  endtask

  // Start the selected instance, wait (bounded) for done/err, compare against
  // the oldest scoreboard entry. hold_start keeps start high in the DONE cycle.
  task automatic run_prog(input bit which, input bit hold_start);
    int   cyc, fet;
    bit   got;
    exp_t e;
    sel = which;
    if (which) start_w = 1'b1; else start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0; start_w = 1'b0;
    cyc = 0; fet = 0; got = 1'b0;
    while (!got && cyc < 300) begin
      if (o_rom_en) fet++;
      @(posedge clk); #1;
      cyc++;
      if (o_done || o_err) got = 1'b1;
    end
    e = sb.pop_front();
    check({e.tag, "/finished"}, 32'(got), 32'd1);
    check({e.tag, "/cycles"},   32'(cyc), 32'(e.cycles));
    check({e.tag, "/fetches"},  32'(fet), 32'(e.fetches));
    check({e.tag, "/done"},     32'(o_done), 32'(e.done));
    check({e.tag, "/err"},      32'(o_err), 32'(e.err));
    check({e.tag, "/acc"},      32'(o_acc), 32'(e.acc));
    check({e.tag, "/c"},        32'(o_c), 32'(e.c));
    check({e.tag, "/z"},        32'(o_z), 32'(e.z));
    if (hold_start) begin
      if (which) start_w = 1'b1; else start_m = 1'b1;
    end
    @(posedge clk); #1;
    start_m = 1'b0; start_w = 1'b0;
    check({e.tag, "/busy_after"}, 32'(o_busy), 32'd0);
    check({e.tag, "/pulse_one"},  32'(o_done | o_err), 32'd0);
    @(posedge clk); #1;
    check({e.tag, "/idle_held"},  32'(o_busy), 32'd0);
    check({e.tag, "/acc_held"},   32'(o_acc), 32'(e.acc));
  endtask

  initial begin
    bit seen;
    clear_rom();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    check("rst/busy", 32'(m_busy), 32'd0);
    check("rst/rom_en", 32'(m_rom_en), 32'd0);
    check("rst/alu_inst", 32'(m_alu_inst), 32'h8);
    check("rst/alu_a", 32'(m_alu_a), 32'd0);
    check("rst/acc", 32'(m_acc), 32'd0);
    check("rst/flags", 32'({m_c, m_z, m_done, m_err}), 32'd0);
    check("rst/w_busy", 32'(w_busy), 32'd0);

    // Load and add; start held in the DONE cycle must be ignored.
    clear_rom();
    set_rom(0, 4'h1, 8'h05); set_rom(1, 4'h2, 8'h03); set_rom(2, 4'hF, 8'h80);
    push_exp("add", 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 10, 3);
    run_prog(1'b0, 1'b1);

    // Decrement of zero borrows.
    clear_rom();
    set_rom(0, 4'h9, 8'h00); set_rom(1, 4'h6, 8'h00); set_rom(2, 4'hF, 8'h80);
    push_exp("dec0", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 10, 3);
    run_prog(1'b0, 1'b0);

    // Bit clear / bit set, carry untouched.
    clear_rom();
    set_rom(0, 4'h1, 8'hF0); set_rom(1, 4'hD, 8'h07); set_rom(2, 4'hE, 8'h00);
    set_rom(3, 4'hF, 8'h80);
    push_exp("bits", 8'h71, 1'b0, 1'b0, 1'b1, 1'b0, 14, 4);
    run_prog(1'b0, 1'b0);

    // Countdown loop: JNZ taken twice, falls through on Z.
    clear_rom();
    set_rom(0, 4'h1, 8'h03); set_rom(1, 4'h6, 8'h00); set_rom(2, 4'hF, 8'h01);
    set_rom(3, 4'hF, 8'h80);
    push_exp("loop", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 24, 8);
    run_prog(1'b0, 1'b0);

    // JNZ to self never writes back: no watchdog abort.
    clear_rom();
    set_rom(0, 4'hF, 8'h00);
    sel = 1'b1;
    start_w = 1'b1;
    @(posedge clk); #1 start_w = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (w_done || w_err) seen = 1'b1;
    end
    check("spin/no_pulse", 32'(seen), 32'd0);
    check("spin/busy", 32'(w_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("spin/reset_idle", 32'(w_busy), 32'd0);

    // Increment loop hits the watchdog after four write-backs.
    clear_rom();
    set_rom(0, 4'h5, 8'h00); set_rom(1, 4'hF, 8'h00);
    push_exp("wdog", 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 22, 7);
    run_prog(1'b1, 1'b0);

    // Reset during EXEC of the second instruction.
    sel = 1'b0;
    clear_rom();
    set_rom(0, 4'h1, 8'h05); set_rom(1, 4'h2, 8'h03); set_rom(2, 4'hF, 8'h80);
    start_m = 1'b1;
    @(posedge clk); #1 start_m = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst/exec_inst", 32'(m_alu_inst), 32'h2);
    check("midrst/exec_a", 32'(m_alu_a), 32'h03);
    check("midrst/acc_before", 32'(m_acc), 32'h05);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midrst/busy", 32'(m_busy), 32'd0);
    check("midrst/acc", 32'(m_acc), 32'd0);
    check("midrst/flags", 32'({m_c, m_z}), 32'd0);
    check("midrst/alu_inst", 32'(m_alu_inst), 32'h8);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_done || m_err || m_busy) seen = 1'b1;
    end
    check("midrst/quiet", 32'(seen), 32'd0);
    push_exp("rerun", 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 10, 3);
    run_prog(1'b0, 1'b0);

    check("sb/empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer that runs a small program from a synchronous instruction ROM on the 8-bit ALU. It owns the accumulator, the program counter and the C/Z flags. It drives ALU opcode and operands, and writes the 9-bit ALU result back. It also implements bit set/clear, conditional jump and halt by rewriting them into ALU ops or handling them in the FSM.

Parameters:
PC_W, 7, program counter / ROM address width; maximum 7, because jump targets are imm[6:0]
WDOG_MAX, 1000, executed-instruction limit before the run is aborted with err

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; one clock; returns block to IDLE
start  input  1  run request; sampled in IDLE only
rom_en  output  1  ROM read enable; high in FETCH only
rom_addr  output  PC_W  ROM address, equal to pc
rom_data  input  12  instruction word, valid the cycle after rom_en; fields op[11:8], imm[7:0]
alu_inst  output  4  ALU opcode
alu_a  output  8  ALU operand a (immediate or mask)
alu_b  output  8  ALU operand b, always acc
alu_ans  input  9  combinational ALU result; bit 8 is carry/borrow
acc_out  output  8  accumulator
flag_c  output  1  carry flag
flag_z  output  1  zero flag
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal halt
err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state=IDLE; pc, acc, flag_c, flag_z, step count = 0; rom_en, busy, done, err = 0; alu_inst=4'h8 (NOP), alu_a=0. Reset mid-run aborts with no done or err pulse.
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE.
- IDLE: start=1 -> FETCH; pc, acc, flags and step count cleared. start in any other state is ignored.
- FETCH: rom_en=1, rom_addr=pc -> DECODE.
- DECODE: latch rom_data into ir.
  - op=4'hF, imm[7]=1 (HALT) -> DONE.
  - op=4'hF, imm[7]=0 (JNZ): if flag_z=0 then pc<=imm[PC_W-1:0], else pc<=pc+1; -> FETCH.
  - op=4'h8 (NOP): pc<=pc+1 -> FETCH.
  - Any other op -> EXEC.
- EXEC: drive the ALU for one cycle: alu_b=acc, alu_inst=op, alu_a=imm, with two rewrites:
  - op 13 (clear bit n=imm[2:0]): alu_inst=4, alu_a=~(8'h01<<n).
  - op 14 (set bit n): alu_inst=10, alu_a=(8'h01<<n).
  -> WB.
- WB: operands held from EXEC.
  - acc<=alu_ans[7:0]; flag_z<=(alu_ans[7:0]==0).
  - flag_c<=alu_ans[8] only for ops 2, 3, 5, 6; otherwise C is unchanged.
  - pc<=pc+1; step<=step+1.
  - step+1==WDOG_MAX -> DONE with err; else -> FETCH.
- DONE: pulse done (normal halt) or err (watchdog), never both -> IDLE. acc and flags hold until the next start.
- Carry source: C comes only from alu_ans[8]; no registered ALU carry output is used.
- Timing per instruction: 4 cycles for ALU instructions (FETCH, DECODE, EXEC, WB); 2 cycles for NOP and JNZ.
- Only WB counts toward the watchdog.
- Outside EXEC/WB: alu_inst=4'h8, alu_a=0.
- Width rules:
  - pc increment wraps modulo 2^PC_W.
  - Subtract and decrement borrow sets bit 8; e.g. dec of 0 gives 9'h1FF, so C=1, acc=FF.
  - Op 9 yields acc=0, Z=1.
  - Op 0 (pass b) rewrites acc unchanged but refreshes Z.
- Same-cycle conflicts: reset wins over everything; start in the DONE cycle is ignored.

Decomposition:
- Package alu_seq_pkg:
  - state enum.
  - ALU opcode constants: OP_PASSB=0, OP_PASSA=1, OP_ADD=2, OP_SUB=3, OP_AND=4, OP_INC=5, OP_DEC=6, OP_XOR=7, OP_NOP=8, OP_CLR=9, OP_IOR=10, OP_SWAP=11, OP_COM=12, OP_BCF=13, OP_BSF=14, OP_CTL=15.
  - Instruction field widths.
- One sub-module, alu_seq_opmap: combinational mapping from op/imm to alu_inst/alu_a, plus the carry-update enable.

Test Plan:
- Program [1:0x05, 2:0x03, F:0x80]: acc=08, C=0, Z=0; done pulses 10 cycles after start; busy low afterwards.
- Program [9:0, 6:0, F:0x80]: acc=FF, C=1 (borrow), Z=0.
- Program [1:0xF0, D:0x07, E:0x00, F:0x80]: acc=71; C unchanged (0).
- Program [1:0x03, 6:0, F:0x01, F:0x80]:
  - JNZ at pc 2 taken twice, falls through once Z=1.
  - Final acc=00, Z=1; done after 3 decrements.
- Program [F:0x00] (JNZ to self with Z=0) and WDOG_MAX=4: loop never executes WB, so no err. Replace with [5:0, F:0x00]: err pulses after 4 WBs, done stays 0.
- Reset asserted in EXEC mid-run: next cycle IDLE, acc=0, flags=0, busy=0, no done or err; a fresh start runs normally.
